alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 32-bit integer ALU for the RISC-Mini core's execute stage.
- Performs R-type arithmetic and logic operations, and evaluates B-type branch conditions.
- Returns a 32-bit result and a 4-bit condition code, one clock after a valid request.
- Opcode is the 7-bit concatenation {function, type}; values come from the shared ISA defines header.

Parameters:
- None. Data width is fixed at 32; opcode width is fixed at 7.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request strobe; a, b and opcode are sampled when high
- a  input  32  operand A (rs1)
- b  input  32  operand B (rs2)
- opcode  input  7  {function[3:0], type[2:0]}
- out_valid  output  1  high for one cycle when alu_out/alu_cc hold a new result
- alu_out  output  32  registered result
- alu_cc  output  4  registered condition code: [0] branch taken, [1] signed overflow, [2] unsigned borrow, [3] zero (optional) else 0

Behaviour:
- Encodings (ISA defines header):
  - Type R_TYPE = 3'b000, B_TYPE = 3'b010.
  - R functions: ADD 0000, SUB 0001, MULT 0010, AND 0011, OR 0100, XOR 0101, NOT 0110.
  - B functions: BEQ 0000, BNE 0001, BLT 0010, BLE 0011, BGT 0100, BGE 0101.
- Reset: on a clk edge with rst=1, alu_out=0, alu_cc=0, out_valid=0. rst has priority over in_valid.
- Latency: exactly 1 cycle. A request sampled at edge N appears on the outputs after edge N, with out_valid=1 for that cycle.
- in_valid=0 at an edge: out_valid goes 0; alu_out and alu_cc hold their previous values.
- Back-to-back requests are accepted every cycle. There is no stall and no backpressure.
- Next-state cc is computed as 4'b0000, then the bits below are set.
- ADD: out = a+b mod 2^32. cc[1] = (a31 & b31 & ~out31) | (~a31 & ~b31 & out31). cc[2]=0 (no carry reported).
- SUB: out = a-b mod 2^32. cc[1] = (a31^b31) & (a31^out31). cc[2] = unsigned a<b.
- MULT: out = low 32 bits of a*b. Signedness is irrelevant for the low half. cc[2:0]=0.
- AND / OR / XOR: bitwise result; cc[2:0]=0.
- NOT: out = ~a; b is ignored; cc[2:0]=0.
- Branches: out = 0.
  - cc[0] = condition: BEQ a==b, BNE a!=b.
  - BLT/BLE/BGT/BGE use signed (two's-complement) comparisons.
  - cc[3:1] = 0.
- Unknown function within R_TYPE or B_TYPE, or any other type value: out=0, cc=0. out_valid is still asserted; no error signalling.
- All arithmetic is combinational, ahead of a single output register stage.

Optional Feature:
- Macro ALU_ZERO_FLAG_EN.
- Defined: for R-type operations, alu_cc[3] = (alu_out next value == 0); branches and unknown opcodes keep cc[3]=0.
- Undefined: alu_cc[3] is tied to 0 for all opcodes. All other bits behave identically in both builds.

Test Plan:
- Reset: assert rst with in_valid=1, ADD 5+7 -> after edge alu_out=0, cc=0000, out_valid=0. Deassert rst, repeat the request -> next cycle alu_out=12, cc=0000, out_valid=1.
- ADD overflow: a=0x7FFFFFFF, b=1 -> out=0x80000000, cc=0010. ADD a=0xFFFFFFFF, b=1 -> out=0, cc=0000, or cc=1000 with ALU_ZERO_FLAG_EN.
- SUB: a=3, b=5 -> out=0xFFFFFFFE, cc=0100. a=0x80000000, b=1 -> out=0x7FFFFFFF, cc=0010. a=b=9 -> out=0, cc=0000, or 1000 with the flag.
- MULT/logic: MULT a=0x10000, b=0x10003 -> out=0x00030000, cc=0000. AND/OR/XOR with 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0. NOT a=0 -> 0xFFFFFFFF.
- Branches: a=0xFFFFFFFF (-1), b=1 -> BLT/BLE/BNE cc=0001, BGT/BGE/BEQ cc=0000, out=0 in all cases. a=b=4 -> BEQ/BLE/BGE cc=0001.
- Handshake: random 10-trial sweep of all 13 ops issued back-to-back, each checked against a golden model one cycle later. Then drop in_valid for 2 cycles -> out_valid=0, alu_out/alu_cc hold. Unknown opcode 7'b1111_111 -> out=0, cc=0000, out_valid=1.

Source files
------------

// File: rtl/alu.sv
// Registered 32-bit ALU: R-type arithmetic/logic and B-type branch evaluation, one-cycle latency.
// Optional build macro ALU_ZERO_FLAG_EN drives alu_cc[3] as a zero flag for R-type results.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [6:0]  opcode,
  output logic        out_valid,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_cc
);

  localparam logic [2:0] R_TYPE = 3'b000;
  localparam logic [2:0] B_TYPE = 3'b010;

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_MULT = 4'b0010;
  localparam logic [3:0] F_AND  = 4'b0011;
  localparam logic [3:0] F_OR   = 4'b0100;
  localparam logic [3:0] F_XOR  = 4'b0101;
  localparam logic [3:0] F_NOT  = 4'b0110;

  localparam logic [3:0] F_BEQ  = 4'b0000;
  localparam logic [3:0] F_BNE  = 4'b0001;
  localparam logic [3:0] F_BLT  = 4'b0010;
  localparam logic [3:0] F_BLE  = 4'b0011;
  localparam logic [3:0] F_BGT  = 4'b0100;
  localparam logic [3:0] F_BGE  = 4'b0101;

  function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] s);
    return (x[31] & y[31] & ~s[31]) | (~x[31] & ~y[31] & s[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] d);
    return (x[31] ^ y[31]) & (x[31] ^ d[31]);
  endfunction

  logic [3:0]         fn;
  logic [2:0]         ty;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [31:0]        sum;
  logic [31:0]        diff;
  logic [31:0]        prod;

  assign fn   = opcode[6:3];
  assign ty   = opcode[2:0];
  assign a_s  = a;
  assign b_s  = b;
  assign sum  = a + b;
  assign diff = a - b;
  assign prod = a * b;

  // Stage p0: combinational result and condition code
  logic [31:0] res_p0;
  logic [3:0]  cc_p0;
  logic        rknown_p0;

  always_comb begin
    res_p0    = '0;
    cc_p0     = 4'b0000;
    rknown_p0 = 1'b0;
    case (ty)
      R_TYPE: begin
        rknown_p0 = 1'b1;
        case (fn)
          F_ADD: begin
            res_p0   = sum;
            cc_p0[1] = add_ovf(a, b, sum);
          end
          F_SUB: begin
            res_p0   = diff;
            cc_p0[1] = sub_ovf(a, b, diff);
            cc_p0[2] = (a < b);
          end
          F_MULT:  res_p0 = prod;
          F_AND:   res_p0 = a & b;
          F_OR:    res_p0 = a | b;
          F_XOR:   res_p0 = a ^ b;
          F_NOT:   res_p0 = ~a;
          default: rknown_p0 = 1'b0;
        endcase
      end
      B_TYPE: begin
        case (fn)
          F_BEQ:   cc_p0[0] = (a == b);
          F_BNE:   cc_p0[0] = (a != b);
          F_BLT:   cc_p0[0] = (a_s < b_s);
          F_BLE:   cc_p0[0] = (a_s <= b_s);
          F_BGT:   cc_p0[0] = (a_s > b_s);
          F_BGE:   cc_p0[0] = (a_s >= b_s);
          default: cc_p0[0] = 1'b0;
        endcase
      end
      default: ;
    endcase
`ifdef ALU_ZERO_FLAG_EN
    cc_p0[3] = rknown_p0 && (res_p0 == 32'd0);
`endif
  end

`ifndef ALU_ZERO_FLAG_EN
  logic unused_p0;
  assign unused_p0 = rknown_p0;
`endif

  // Stage p1: output register; outputs hold while no request is presented
  logic        vld_p1;
  logic [31:0] res_p1;
  logic [3:0]  cc_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      cc_p1  <= 4'b0000;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1 <= res_p0;
        cc_p1  <= cc_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign alu_out   = res_p1;
  assign alu_cc    = cc_p1;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: per-cycle comparison against an arithmetic reference model,
// plus directed vectors with hand-computed expectations that also pin the model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [6:0]  opcode;
  logic        out_valid;
  logic [31:0] alu_out;
  logic [3:0]  alu_cc;

  always #5 clk = ~clk;

  alu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .opcode(opcode),
    .out_valid(out_valid), .alu_out(alu_out), .alu_cc(alu_cc)
  );

  localparam logic [6:0] ADD = 7'h00, SUB = 7'h08, MULT = 7'h10, AND_ = 7'h18,
                         OR_ = 7'h20, XOR_ = 7'h28, NOT_ = 7'h30;
  localparam logic [6:0] BEQ = 7'h02, BNE = 7'h0A, BLT = 7'h12, BLE = 7'h1A,
                         BGT = 7'h22, BGE = 7'h2A;
`ifdef ALU_ZERO_FLAG_EN
  localparam logic [3:0] ZF = 4'b1000;
`else
  localparam logic [3:0] ZF = 4'b0000;
`endif

  // Reference: result and cc from plain integer arithmetic.
  function automatic logic [35:0] golden(input logic [6:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [31:0] r;
    logic [3:0]  c;
    longint      sx, sy, s;
    bit          rk;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 32'd0; c = 4'd0; rk = 1'b0;
    case (op)
      ADD:  begin s = sx + sy; r = x + y; c[1] = (s != longint'($signed(r))); rk = 1; end
      SUB:  begin s = sx - sy; r = x - y; c[1] = (s != longint'($signed(r)));
                  c[2] = (x < y); rk = 1; end
      MULT: begin r = x * y; rk = 1; end
      AND_: begin r = x & y; rk = 1; end
      OR_:  begin r = x | y; rk = 1; end
      XOR_: begin r = x ^ y; rk = 1; end
      NOT_: begin r = ~x; rk = 1; end
      BEQ:  c[0] = (sx == sy);
      BNE:  c[0] = (sx != sy);
      BLT:  c[0] = (sx < sy);
      BLE:  c[0] = (sx <= sy);
      BGT:  c[0] = (sx > sy);
      BGE:  c[0] = (sx >= sy);
      default: ;
    endcase
    if (rk && r == 32'd0) c[3] = ZF[3];
    return {c, r};
  endfunction

  logic        m_vld = 1'b0;
  logic [31:0] m_out = '0;
  logic [3:0]  m_cc  = '0;

  logic        lit_en = 1'b0, lit_vld = 1'b0;
  logic [31:0] lit_out = '0;
  logic [3:0]  lit_cc = '0;
  string       lit_name = "";
  logic        l_chk = 1'b0, l_vld = 1'b0;
  logic [31:0] l_out = '0;
  logic [3:0]  l_cc = '0;
  string       l_name = "";

  int passed = 0;
  int total  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_vld = 1'b0; m_out = '0; m_cc = '0;
    end else begin
      m_vld = in_valid;
      if (in_valid) {m_cc, m_out} = golden(opcode, a, b);
    end
    l_chk = lit_en; l_vld = lit_vld; l_out = lit_out; l_cc = lit_cc; l_name = lit_name;
  end

  always @(negedge clk) begin
    total++;
    if ({out_valid, alu_out, alu_cc} === {m_vld, m_out, m_cc}) passed++;
    else $display("FAIL model t=%0t: got vld=%b out=%h cc=%b, want vld=%b out=%h cc=%b",
                  $time, out_valid, alu_out, alu_cc, m_vld, m_out, m_cc);
    if (l_chk) begin
      total++;
      if ({out_valid, alu_out, alu_cc} === {l_vld, l_out, l_cc}) passed++;
      else $display("FAIL %s: got vld=%b out=%h cc=%b, want vld=%b out=%h cc=%b",
                    l_name, out_valid, alu_out, alu_cc, l_vld, l_out, l_cc);
      total++;
      if ({m_vld, m_out, m_cc} === {l_vld, l_out, l_cc}) passed++;
      else $display("FAIL %s_model_pin: model vld=%b out=%h cc=%b, want vld=%b out=%h cc=%b",
                    l_name, m_vld, m_out, m_cc, l_vld, l_out, l_cc);
    end
  end

  task automatic issue(input logic v, input logic [6:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic le, input string nm,
                       input logic ev, input logic [31:0] eo, input logic [3:0] ec);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = v; opcode = op; a = x; b = y;
    lit_en = le; lit_name = nm; lit_vld = ev; lit_out = eo; lit_cc = ec;
  endtask

  logic [6:0] ops [13] = '{ADD, SUB, MULT, AND_, OR_, XOR_, NOT_, BEQ, BNE, BLT, BLE, BGT, BGE};

  initial begin
    rst = 1'b1; in_valid = 1'b1; opcode = ADD; a = 32'd5; b = 32'd7;
    lit_en = 1'b1; lit_name = "reset"; lit_vld = 1'b0; lit_out = '0; lit_cc = '0;

    issue(1, ADD,  32'd5,        32'd7,        1, "add_basic", 1, 32'd12,       4'b0000);
    issue(1, ADD,  32'h7FFFFFFF, 32'd1,        1, "add_ovf",   1, 32'h80000000, 4'b0010);
    issue(1, ADD,  32'hFFFFFFFF, 32'd1,        1, "add_wrap",  1, 32'd0,        ZF);
    issue(1, SUB,  32'd3,        32'd5,        1, "sub_borrow",1, 32'hFFFFFFFE, 4'b0100);
    issue(1, SUB,  32'h80000000, 32'd1,        1, "sub_ovf",   1, 32'h7FFFFFFF, 4'b0010);
    issue(1, SUB,  32'd9,        32'd9,        1, "sub_zero",  1, 32'd0,        ZF);
    issue(1, MULT, 32'h10000,    32'h10003,    1, "mult",      1, 32'h00030000, 4'b0000);
    issue(1, AND_, 32'hF0F0F0F0, 32'hFF00FF00, 1, "and",       1, 32'hF000F000, 4'b0000);
    issue(1, OR_,  32'hF0F0F0F0, 32'hFF00FF00, 1, "or",        1, 32'hFFF0FFF0, 4'b0000);
    issue(1, XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 1, "xor",       1, 32'h0FF00FF0, 4'b0000);
    issue(1, NOT_, 32'd0,        32'h12345678, 1, "not",       1, 32'hFFFFFFFF, 4'b0000);
    issue(1, BLT,  32'hFFFFFFFF, 32'd1,        1, "blt_neg",   1, 32'd0,        4'b0001);
    issue(1, BLE,  32'hFFFFFFFF, 32'd1,        1, "ble_neg",   1, 32'd0,        4'b0001);
    issue(1, BNE,  32'hFFFFFFFF, 32'd1,        1, "bne_neg",   1, 32'd0,        4'b0001);
    issue(1, BGT,  32'hFFFFFFFF, 32'd1,        1, "bgt_neg",   1, 32'd0,        4'b0000);
    issue(1, BGE,  32'hFFFFFFFF, 32'd1,        1, "bge_neg",   1, 32'd0,        4'b0000);
    issue(1, BEQ,  32'hFFFFFFFF, 32'd1,        1, "beq_neg",   1, 32'd0,        4'b0000);
    issue(1, BEQ,  32'd4,        32'd4,        1, "beq_eq",    1, 32'd0,        4'b0001);
    issue(1, BLE,  32'd4,        32'd4,        1, "ble_eq",    1, 32'd0,        4'b0001);
    issue(1, BGE,  32'd4,        32'd4,        1, "bge_eq",    1, 32'd0,        4'b0001);

    for (int t = 0; t < 10; t++)
      for (int k = 0; k < 13; k++)
        issue(1, ops[k], $urandom, $urandom, 0, "", 0, '0, '0);

    issue(1, XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 1, "xor_pre_idle", 1, 32'h0FF00FF0, 4'b0000);
    issue(0, ADD,  32'h7FFFFFFF, 32'd1,        1, "idle_hold1",   0, 32'h0FF00FF0, 4'b0000);
    issue(0, SUB,  32'd3,        32'd5,        1, "idle_hold2",   0, 32'h0FF00FF0, 4'b0000);
    issue(1, 7'h7F, 32'd1,       32'd2,        1, "unknown_op",   1, 32'd0,        4'b0000);
    issue(1, 7'h38, 32'd1,       32'd2,        1, "unknown_rfn",  1, 32'd0,        4'b0000);
    issue(0, ADD,  32'd0,        32'd0,        0, "",             0, '0,           '0);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
